// File: rtl/vmicro16_uart_rx_apb_pkg.sv
// Shared definitions for the APB UART receiver: register offsets, STATUS bit
// positions and the 2-bit receive FSM encodings.
package vmicro16_uart_rx_apb_pkg;

    localparam logic [1:0] REG_DATA   = 2'd0;
    localparam logic [1:0] REG_STATUS = 2'd1;

    localparam int BIT_NE   = 0;
    localparam int BIT_FULL = 1;
    localparam int BIT_OVR  = 2;
    localparam int BIT_FERR = 3;

    localparam logic [1:0] ST_IDLE  = 2'd0;
    localparam logic [1:0] ST_START = 2'd1;
    localparam logic [1:0] ST_DATA  = 2'd2;
    localparam logic [1:0] ST_STOP  = 2'd3;

endpackage

// File: rtl/vmicro16_uart_rx_core.sv
// 8N1 serial receiver: two-flop synchroniser feeding a bit-timing FSM that
// emits one-cycle pulses for a good byte or a framing error.
module vmicro16_uart_rx_core
    import vmicro16_uart_rx_apb_pkg::*;
#(
    parameter int CLKS_PER_BIT = 434
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       uart_rx,
    output logic [7:0] rx_byte,
    output logic       rx_valid,
    output logic       rx_ferr
);

    localparam int CNT_W = $clog2(CLKS_PER_BIT);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(CLKS_PER_BIT - 1);
    localparam logic [CNT_W-1:0] CNT_MID  = CNT_W'(CLKS_PER_BIT / 2 - 1);

    logic             r_sync1;
    logic             r_sync2;
    logic [1:0]       r_state;
    logic [CNT_W-1:0] r_cnt;
    logic [2:0]       r_idx;
    logic [7:0]       r_sr;
    logic             r_valid;
    logic             r_ferr;

    // Synchroniser resets to the idle level so reset never looks like a start bit.
    always_ff @(posedge clk) begin
        if (!reset) begin
            r_sync1 <= 1'b1;
            r_sync2 <= 1'b1;
        end else begin
            r_sync1 <= uart_rx;
            r_sync2 <= r_sync1;
        end
    end

    always_ff @(posedge clk) begin
        if (!reset) begin
            r_state <= ST_IDLE;
            r_cnt   <= '0;
            r_idx   <= '0;
            r_valid <= 1'b0;
            r_ferr  <= 1'b0;
        end else begin
            r_valid <= 1'b0;
            r_ferr  <= 1'b0;
            case (r_state)
                ST_IDLE: begin
                    if (!r_sync2) begin
                        r_state <= ST_START;
                        r_cnt   <= '0;
                    end
                end
                ST_START: begin
                    if (r_cnt == CNT_MID) begin
                        r_cnt   <= '0;
                        r_idx   <= '0;
                        r_state <= r_sync2 ? ST_IDLE : ST_DATA;
                    end else begin
                        r_cnt <= r_cnt + 1'b1;
                    end
                end
                ST_DATA: begin
                    if (r_cnt == CNT_LAST) begin
                        r_cnt <= '0;
                        r_idx <= r_idx + 1'b1;
                        if (r_idx == 3'd7)
                            r_state <= ST_STOP;
                    end else begin
                        r_cnt <= r_cnt + 1'b1;
                    end
                end
                default: begin
                    // Leaving at mid-stop-bit lets the next start edge be caught immediately.
                    if (r_cnt == CNT_LAST) begin
                        r_cnt   <= '0;
                        r_state <= ST_IDLE;
                        r_valid <= r_sync2;
                        r_ferr  <= !r_sync2;
                    end else begin
                        r_cnt <= r_cnt + 1'b1;
                    end
                end
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (r_state == ST_DATA && r_cnt == CNT_LAST)
            r_sr[r_idx] <= r_sync2;
    end

    assign rx_byte  = r_sr;
    assign rx_valid = r_valid;
    assign rx_ferr  = r_ferr;

endmodule

// File: rtl/vmicro16_uart_rx_apb.sv
// APB slave wrapper for the UART receiver: RX FIFO, sticky OVR/FERR flags and
// the DATA/STATUS register decode with zero-wait-state access.
module vmicro16_uart_rx_apb
    import vmicro16_uart_rx_apb_pkg::*;
#(
    parameter int BUS_WIDTH    = 16,
    parameter int CLKS_PER_BIT = 434,
    parameter int FIFO_DEPTH   = 4
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic [15:0]          S_PADDR,
    input  logic                 S_PWRITE,
    input  logic                 S_PSELx,
    input  logic                 S_PENABLE,
    input  logic [BUS_WIDTH-1:0] S_PWDATA,
    output logic [BUS_WIDTH-1:0] S_PRDATA,
    output logic                 S_PREADY,
    input  logic                 uart_rx
);

    localparam int PTR_W = $clog2(FIFO_DEPTH);
    localparam int CNT_W = $clog2(FIFO_DEPTH + 1);
    localparam logic [CNT_W-1:0] FIFO_FULL = CNT_W'(FIFO_DEPTH);

    logic [7:0]       w_rx_byte;
    logic             w_rx_valid;
    logic             w_rx_ferr;
    logic             w_access;
    logic             w_rd;
    logic             w_wr;
    logic             w_empty;
    logic             w_full;
    logic             w_pop;
    logic             w_push;
    logic             w_drop;
    logic             w_clr;
    logic             w_unused;

    logic [7:0]       r_mem [FIFO_DEPTH];
    logic [PTR_W-1:0] r_wr_ptr;
    logic [PTR_W-1:0] r_rd_ptr;
    logic [CNT_W-1:0] r_count;
    logic             r_ovr;
    logic             r_ferr;

    vmicro16_uart_rx_core #(
        .CLKS_PER_BIT(CLKS_PER_BIT)
    ) u_core (
        .clk      (clk),
        .reset    (reset),
        .uart_rx  (uart_rx),
        .rx_byte  (w_rx_byte),
        .rx_valid (w_rx_valid),
        .rx_ferr  (w_rx_ferr)
    );

    assign w_access = S_PSELx & S_PENABLE;
    assign w_rd     = w_access & !S_PWRITE;
    assign w_wr     = w_access & S_PWRITE;
    assign w_empty  = (r_count == '0);
    assign w_full   = (r_count == FIFO_FULL);
    assign w_pop    = w_rd && (S_PADDR[1:0] == REG_DATA) && !w_empty;
    // A full FIFO still accepts a byte when the head is leaving in the same cycle.
    assign w_push   = w_rx_valid && (!w_full || w_pop);
    assign w_drop   = w_rx_valid && w_full && !w_pop;
    assign w_clr    = w_wr && (S_PADDR[1:0] == REG_STATUS);
    assign w_unused = ^{S_PADDR[15:2], S_PWDATA};
    assign S_PREADY = w_access;

    always_ff @(posedge clk) begin
        if (!reset) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
        end else begin
            if (w_push)
                r_wr_ptr <= r_wr_ptr + 1'b1;
            if (w_pop)
                r_rd_ptr <= r_rd_ptr + 1'b1;
            if (w_push && !w_pop)
                r_count <= r_count + 1'b1;
            else if (!w_push && w_pop)
                r_count <= r_count - 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (w_push)
            r_mem[r_wr_ptr] <= w_rx_byte;
    end

    // Set has priority over a same-cycle W1C clear.
    always_ff @(posedge clk) begin
        if (!reset) begin
            r_ovr  <= 1'b0;
            r_ferr <= 1'b0;
        end else begin
            r_ovr  <= w_drop    | (r_ovr  & !(w_clr & S_PWDATA[BIT_OVR]));
            r_ferr <= w_rx_ferr | (r_ferr & !(w_clr & S_PWDATA[BIT_FERR]));
        end
    end

    always_comb begin
        S_PRDATA = '0;
        if (w_rd) begin
            case (S_PADDR[1:0])
                REG_DATA: begin
                    if (!w_empty)
                        S_PRDATA = BUS_WIDTH'(r_mem[r_rd_ptr]);
                end
                REG_STATUS: begin
                    S_PRDATA[BIT_NE]   = !w_empty;
                    S_PRDATA[BIT_FULL] = w_full;
                    S_PRDATA[BIT_OVR]  = r_ovr;
                    S_PRDATA[BIT_FERR] = r_ferr;
                end
                default: S_PRDATA = '0;
            endcase
        end
    end

endmodule

// File: tb/tb_vmicro16_uart_rx_apb.sv
// Directed bench for the APB UART receiver with a queue-based reference model
// and an every-cycle comparison of the APB read path.
module tb_vmicro16_uart_rx_apb;

    localparam int CPB   = 8;
    localparam int DEPTH = 4;

    logic        clk = 1'b0;
    logic        reset = 1'b0;
    logic [15:0] S_PADDR = '0;
    logic        S_PWRITE = 1'b0;
    logic        S_PSELx = 1'b0;
    logic        S_PENABLE = 1'b0;
    logic [15:0] S_PWDATA = '0;
    logic [15:0] S_PRDATA;
    logic        S_PREADY;
    logic        uart_rx = 1'b1;

    int checks = 0;
    int errors = 0;

    logic [7:0] m_q [$];
    logic       m_ovr = 1'b0;
    logic       m_ferr = 1'b0;

    vmicro16_uart_rx_apb #(
        .BUS_WIDTH(16), .CLKS_PER_BIT(CPB), .FIFO_DEPTH(DEPTH)
    ) dut (
        .clk(clk), .reset(reset), .S_PADDR(S_PADDR), .S_PWRITE(S_PWRITE),
        .S_PSELx(S_PSELx), .S_PENABLE(S_PENABLE), .S_PWDATA(S_PWDATA),
        .S_PRDATA(S_PRDATA), .S_PREADY(S_PREADY), .uart_rx(uart_rx)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input logic [15:0] act, input logic [15:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s got=%h want=%h at %0t", name, act, exp, $time);
        end
    endtask

    function automatic logic [15:0] model_rd(input logic wr, input logic [1:0] a);
        if (wr) return 16'h0000;
        case (a)
            2'd0: return (m_q.size() != 0) ? {8'h00, m_q[0]} : 16'h0000;
            2'd1: return {12'h000, m_ferr, m_ovr, m_q.size() == DEPTH, m_q.size() != 0};
            default: return 16'h0000;
        endcase
    endfunction

    // Outputs are stable mid-low-phase; model changes only at negedges.
    always @(negedge clk) begin
        #2;
        if (S_PSELx && S_PENABLE) begin
            check("prdata", S_PRDATA, model_rd(S_PWRITE, S_PADDR[1:0]));
            check("pready", {15'h0, S_PREADY}, 16'h0001);
        end else begin
            check("prdata_idle", S_PRDATA, 16'h0000);
            check("pready_idle", {15'h0, S_PREADY}, 16'h0000);
        end
    end

    task automatic apb(input logic wr, input logic [1:0] a, input logic [15:0] wd,
                       output logic [15:0] rd, output logic rdy);
        @(negedge clk);
        S_PSELx = 1'b1; S_PENABLE = 1'b0; S_PWRITE = wr;
        S_PADDR = {14'h0, a}; S_PWDATA = wd;
        @(negedge clk);
        S_PENABLE = 1'b1;
        #2;
        rd  = S_PRDATA;
        rdy = S_PREADY;
        @(negedge clk);
        S_PSELx = 1'b0; S_PENABLE = 1'b0; S_PWRITE = 1'b0;
        if (!wr && a == 2'd0 && m_q.size() != 0) void'(m_q.pop_front());
        if (wr && a == 2'd1) begin
            if (wd[2]) m_ovr = 1'b0;
            if (wd[3]) m_ferr = 1'b0;
        end
    endtask

    task automatic rd_chk(input string name, input logic [1:0] a, input logic [15:0] exp);
        logic [15:0] rd;
        logic rdy;
        apb(1'b0, a, 16'h0, rd, rdy);
        check(name, rd, exp);
    endtask

    task automatic wr_reg(input logic [1:0] a, input logic [15:0] wd);
        logic [15:0] rd;
        logic rdy;
        apb(1'b1, a, wd, rd, rdy);
    endtask

    task automatic send_frame(input logic [7:0] b, input logic stop_bit);
        logic [9:0] bits;
        bits = {stop_bit, b, 1'b0};
        for (int i = 0; i < 10; i++) begin
            uart_rx = bits[i];
            repeat (CPB) @(negedge clk);
        end
        uart_rx = 1'b1;
        if (!stop_bit) m_ferr = 1'b1;
        else if (m_q.size() == DEPTH) m_ovr = 1'b1;
        else m_q.push_back(b);
    endtask

    task automatic idle(input int n);
        repeat (n) @(negedge clk);
    endtask

    initial begin
        logic [15:0] rd;
        logic rdy;
        logic [7:0] partial;

        repeat (3) @(negedge clk);
        reset = 1'b1;
        idle(2);
        rd_chk("reset_status", 2'd1, 16'h0000);
        rd_chk("reset_data", 2'd0, 16'h0000);

        send_frame(8'h55, 1'b1);
        idle(CPB);
        rd_chk("f55_status", 2'd1, 16'h0001);
        rd_chk("f55_data", 2'd0, 16'h0055);
        rd_chk("f55_status_after", 2'd1, 16'h0000);

        uart_rx = 1'b0;
        idle(2);
        uart_rx = 1'b1;
        idle(2 * CPB);
        rd_chk("glitch_status", 2'd1, 16'h0000);

        for (int i = 1; i <= 5; i++) send_frame(8'(i), 1'b1);
        idle(CPB);
        rd_chk("ovf_status", 2'd1, 16'h0007);
        rd_chk("ovf_data1", 2'd0, 16'h0001);
        rd_chk("ovf_data2", 2'd0, 16'h0002);
        rd_chk("ovf_data3", 2'd0, 16'h0003);
        rd_chk("ovf_data4", 2'd0, 16'h0004);
        rd_chk("ovf_status_drained", 2'd1, 16'h0004);
        wr_reg(2'd1, 16'h0003);
        rd_chk("w1c_other_bits", 2'd1, 16'h0004);
        wr_reg(2'd1, 16'h0004);
        rd_chk("w1c_ovr", 2'd1, 16'h0000);

        send_frame(8'hA5, 1'b0);
        idle(2 * CPB);
        rd_chk("ferr_status", 2'd1, 16'h0008);
        apb(1'b0, 2'd0, 16'h0, rd, rdy);
        check("empty_data", rd, 16'h0000);
        check("empty_pready", {15'h0, rdy}, 16'h0001);
        rd_chk("ferr_status_kept", 2'd1, 16'h0008);
        wr_reg(2'd0, 16'h00FF);
        rd_chk("data_write_ignored", 2'd1, 16'h0008);
        wr_reg(2'd1, 16'h0008);
        rd_chk("w1c_ferr", 2'd1, 16'h0000);

        send_frame(8'h77, 1'b1);
        send_frame(8'h12, 1'b0);
        idle(2 * CPB);
        rd_chk("pre_reset_status", 2'd1, 16'h0009);
        rd_chk("reg2_zero", 2'd2, 16'h0000);

        partial = 8'h3C;
        uart_rx = 1'b0;
        idle(CPB);
        for (int i = 0; i < 3; i++) begin
            uart_rx = partial[i];
            idle(CPB);
        end
        uart_rx = partial[3];
        idle(CPB / 2);
        reset = 1'b0;
        m_q.delete();
        m_ovr = 1'b0;
        m_ferr = 1'b0;
        idle(1);
        reset = 1'b1;
        uart_rx = 1'b1;
        idle(3 * CPB);
        rd_chk("post_reset_status", 2'd1, 16'h0000);
        rd_chk("post_reset_data", 2'd0, 16'h0000);
        send_frame(8'h3C, 1'b1);
        idle(CPB);
        rd_chk("f3c_status", 2'd1, 16'h0001);
        rd_chk("f3c_data", 2'd0, 16'h003C);
        rd_chk("f3c_status_after", 2'd1, 16'h0000);

        idle(2);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
